// File: rtl/pingpong_bank_ctrl.sv
// Ping-pong SRAM bank sequencer: tracks frame occupancy of the two banks, swaps the
// read/write roles through a one-cycle SWAP guard state, and flags protocol violations.
module pingpong_bank_ctrl #(
  parameter int       CNT_W    = 16,
  parameter bit       INIT_SEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_done,
  input  logic             rd_done,
  input  logic             flush,
  input  logic             err_clr,
  output logic             sram_read_register,
  output logic             wr_ready,
  output logic             rd_valid,
  output logic [CNT_W-1:0] swap_count,
  output logic             err_wr,
  output logic             err_rd,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,
    ST_RD_FULL   = 2'd1,
    ST_BOTH_FULL = 2'd2,
    ST_SWAP      = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic             sel_reg, sel_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             err_wr_reg, err_wr_next;
  logic             err_rd_reg, err_rd_next;

  logic             wr_acc, rd_acc;
  logic             ready_int, valid_int;

  assign ready_int = (state_reg == ST_EMPTY) || (state_reg == ST_RD_FULL);
  assign valid_int = (state_reg == ST_RD_FULL) || (state_reg == ST_BOTH_FULL);

  // Flush masks both handshakes so a flushed pulse neither moves state nor raises an error.
  assign wr_acc = wr_done & ready_int & ~flush;
  assign rd_acc = rd_done & valid_int & ~flush;

  always_comb begin
    state_next  = state_reg;
    sel_next    = sel_reg;
    count_next  = count_reg;
    err_wr_next = err_clr ? 1'b0 : err_wr_reg;
    err_rd_next = err_clr ? 1'b0 : err_rd_reg;

    if (!flush) begin
      if (wr_done && !ready_int) err_wr_next = 1'b1;
      if (rd_done && !valid_int) err_rd_next = 1'b1;
    end

    if (flush) begin
      state_next = ST_EMPTY;
    end else begin
      unique case (state_reg)
        ST_EMPTY: begin
          if (wr_acc) state_next = ST_SWAP;
        end
        ST_RD_FULL: begin
          if (wr_acc && rd_acc) state_next = ST_SWAP;
          else if (wr_acc)      state_next = ST_BOTH_FULL;
          else if (rd_acc)      state_next = ST_EMPTY;
        end
        ST_BOTH_FULL: begin
          if (rd_acc) state_next = ST_SWAP;
        end
        ST_SWAP: begin
          state_next = ST_RD_FULL;
        end
        default: state_next = ST_EMPTY;
      endcase
    end

    // Bank roles flip on the same edge that enters SWAP.
    if (state_next == ST_SWAP && state_reg != ST_SWAP) begin
      sel_next   = ~sel_reg;
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_EMPTY;
      sel_reg    <= INIT_SEL;
      count_reg  <= '0;
      err_wr_reg <= 1'b0;
      err_rd_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      sel_reg    <= sel_next;
      count_reg  <= count_next;
      err_wr_reg <= err_wr_next;
      err_rd_reg <= err_rd_next;
    end
  end

  assign sram_read_register = sel_reg;
  assign wr_ready           = ready_int;
  assign rd_valid           = valid_int;
  assign swap_count         = count_reg;
  assign err_wr             = err_wr_reg;
  assign err_rd             = err_rd_reg;
  assign state              = state_reg;

endmodule

// File: tb/tb_pingpong_bank_ctrl.sv
// Directed bench for pingpong_bank_ctrl (CNT_W=2 so counter wrap is reachable).
// Observed vector = {state[1:0], sel, wr_ready, rd_valid, swap_count[1:0], err_wr, err_rd}.
module tb_pingpong_bank_ctrl;

  logic       clk = 1'b0;
  logic       rst, wr_done, rd_done, flush, err_clr;
  logic       sram_read_register, wr_ready, rd_valid, err_wr, err_rd;
  logic [1:0] swap_count;
  logic [1:0] state;
  logic [8:0] obs;
  logic [8:0] exp_v;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  pingpong_bank_ctrl #(.CNT_W(2), .INIT_SEL(1'b0)) dut (
    .clk(clk), .rst(rst), .wr_done(wr_done), .rd_done(rd_done), .flush(flush),
    .err_clr(err_clr), .sram_read_register(sram_read_register), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .swap_count(swap_count), .err_wr(err_wr), .err_rd(err_rd),
    .state(state)
  );

  assign obs = {state, sram_read_register, wr_ready, rd_valid, swap_count, err_wr, err_rd};

  // Apply the currently driven inputs for one edge, then release the pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    wr_done = 1'b0; rd_done = 1'b0; flush = 1'b0; err_clr = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_done = 1'b0; rd_done = 1'b0; flush = 1'b0; err_clr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    tick();
    exp_v = {2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL reset got=%b exp=%b", obs, exp_v); end
  endtask

  task automatic test_first_frame();
    repeat (2) tick();
    wr_done = 1'b1; tick();
    exp_v = {2'd3, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0};
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL first_swap got=%b exp=%b", obs, exp_v); end
    tick();
    exp_v = {2'd1, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0};
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL first_rd_full got=%b exp=%b", obs, exp_v); end
  endtask

  task automatic test_backpressure();
    wr_done = 1'b1; tick();
    exp_v = {2'd2, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0};
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL bp_both_full got=%b exp=%b", obs, exp_v); end
    wr_done = 1'b1; tick();
    exp_v = {2'd2, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0};
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL bp_err_wr got=%b exp=%b", obs, exp_v); end
    rd_done = 1'b1; tick();
    exp_v = {2'd3, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0};
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL bp_swap got=%b exp=%b", obs, exp_v); end
    tick();
    exp_v = {2'd1, 1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0};
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL bp_rd_full got=%b exp=%b", obs, exp_v); end
  endtask

  task automatic test_simultaneous();
    wr_done = 1'b1; rd_done = 1'b1; tick();
    exp_v = {2'd3, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0};
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL simul_swap got=%b exp=%b", obs, exp_v); end
    tick();
    exp_v = {2'd1, 1'b1, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0};
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL simul_rd_full got=%b exp=%b", obs, exp_v); end
  endtask

  task automatic test_flush();
    wr_done = 1'b1; tick();
    exp_v = {2'd2, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0};
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL flush_setup got=%b exp=%b", obs, exp_v); end
    flush = 1'b1; rd_done = 1'b1; tick();
    exp_v = {2'd0, 1'b1, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0};
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL flush_both_full got=%b exp=%b", obs, exp_v); end
    err_clr = 1'b1; tick();
    exp_v = {2'd0, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0};
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL err_clr_wr got=%b exp=%b", obs, exp_v); end
    // Counter wraps 3 -> 0 on this swap.
    wr_done = 1'b1; tick();
    exp_v = {2'd3, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL wrap_swap got=%b exp=%b", obs, exp_v); end
    flush = 1'b1; tick();
    exp_v = {2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL flush_in_swap got=%b exp=%b", obs, exp_v); end
  endtask

  task automatic test_reset_in_swap();
    wr_done = 1'b1; tick();
    exp_v = {2'd3, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0};
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL rsw_swap got=%b exp=%b", obs, exp_v); end
    rst = 1'b1; tick();
    exp_v = {2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL rsw_reset got=%b exp=%b", obs, exp_v); end
  endtask

  task automatic test_wrap_errors();
    logic       sel_m;
    logic [1:0] cnt_m;
    sel_m = 1'b0; cnt_m = 2'd0;
    for (int i = 0; i < 5; i++) begin
      wr_done = 1'b1; tick();
      sel_m = ~sel_m; cnt_m = cnt_m + 2'd1;
      exp_v = {2'd3, sel_m, 1'b0, 1'b0, cnt_m, 1'b0, 1'b0};
      checks++; if (obs !== exp_v) begin failures++; $display("FAIL wrap_swap_%0d got=%b exp=%b", i, obs, exp_v); end
      tick();
      rd_done = 1'b1; tick();
    end
    exp_v = {2'd0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0};
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL wrap_final got=%b exp=%b", obs, exp_v); end
    rd_done = 1'b1; tick();
    exp_v = {2'd0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1};
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL err_rd_set got=%b exp=%b", obs, exp_v); end
    err_clr = 1'b1; tick();
    exp_v = {2'd0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0};
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL err_rd_clr got=%b exp=%b", obs, exp_v); end
    err_clr = 1'b1; rd_done = 1'b1; tick();
    exp_v = {2'd0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1};
    checks++; if (obs !== exp_v) begin failures++; $display("FAIL err_set_wins got=%b exp=%b", obs, exp_v); end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_backpressure();
    test_simultaneous();
    test_flush();
    test_reset_in_swap();
    test_reset();
    test_wrap_errors();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
